endscreen_palette_encoder: RTL and testbench
============================================

Name: endscreen_palette_encoder

Overview:
- Reverse of the end-screen palette lookup: takes a 12-bit RGB pixel (4 bits per channel) and returns the 3-bit index of the nearest palette entry.
- Used by the frame-capture/recolour path to re-quantise composited pixels into the same 8-entry index space that the end-screen ROM and palette use.
- Iterative search, one palette entry per cycle, with valid/ready handshakes on both the input and output sides.

Parameters:
- NUM_ENTRIES, 8, number of palette entries searched. Fixed by the palette package; indices are 3 bits.
- EARLY_EXIT, 1, when 1 the search terminates on an exact match (distance 0).

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  encoder can accept a pixel.
- red, green, blue  in  4 each  input pixel channels.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- index  out  3  nearest palette index.
- distance  out  10  squared distance to the chosen entry.

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, index=0, distance=0, internal counter=0, best distance=10'h3FF.
- States: IDLE, SEARCH, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge N: latch the RGB value, set counter k=0 and best=3FF, then go to SEARCH.
- SEARCH: in_ready=0. In each cycle the block computes d = (r-Pr[k])^2 + (g-Pg[k])^2 + (b-Pb[k])^2.
  - Channel differences are unsigned absolute values, 4 bits; each square is 8 bits (max 225); the sum is 10 bits (max 675). There is no overflow.
  - The best result is updated only if d < best (strict). Ties therefore keep the lower index.
  - Go to DONE when k==NUM_ENTRIES-1, or when EARLY_EXIT and d==0. Otherwise k increments.
- Latency: entry k is compared in cycle N+1+k. out_valid rises in cycle N+2 on an exact match at entry 0, N+1+j+1 on an exact match at entry j, and N+9 for a full search.
- DONE: out_valid=1. index and distance are registered and hold stable while out_ready=0 (indefinite backpressure). On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle. The block does not accept a new pixel in the same cycle as the output handshake.
- Input RGB changes while in SEARCH or DONE are ignored, because the latched copy is used.
- Reset mid-search or in DONE: immediately returns to the reset values. The partial result is discarded and never presented.
- in_valid asserted while in_ready=0 has no effect. The source must hold the pixel until accepted.
- Palette contents (must match the end-screen palette):
  - 0=000, 1=E79, 2=169, 3=931
  - 4=8CD, 5=EB8, 6=510, 7=B75

Decomposition:
- Shared package endscreen_pkg contains:
  - PALETTE constant array[8] of 12-bit RGB, the single source for both the lookup and this encoder.
  - IDX_W=3, DIST_W=10.
  - state enum (IDLE, SEARCH, DONE).
- Sub-module color_sq_dist (combinational): two 12-bit RGB inputs, 10-bit squared-distance output. It is reusable by other quantisers.

Test Plan:
- Exact match, early exit: pixel 000 accepted at edge N -> out_valid in cycle N+2, index=0, distance=0.
- Full search: pixel FFF -> out_valid at N+9, index=4, distance=62 (entry 5 gives 66, entry 1 gives 101).
- Tie-break: pixel C97 (entries 5 and 7 are both at distance 9) -> index=5, distance=9. Also pixel B75 -> index=7, distance=0 at N+9.
- Backpressure: after the FFF result, hold out_ready=0 for 5 cycles -> out_valid stays 1, index=4 and distance=62 stay stable, in_ready=0. Raise out_ready -> next cycle out_valid=0 and in_ready=1.
- Reset mid-search: deassert Reset_n at cycle N+4 of a search -> outputs take reset values asynchronously. After release, pixel E79 -> index=1, distance=0. No stale result appears.
- Back-to-back stream with out_ready=1 and randomised in_valid gaps over all 4096 RGB values -> every index/distance matches a reference model (min distance, lowest index on ties), and no pixel is lost or duplicated.

Source files
------------

// File: rtl/endscreen_pkg.sv
// endscreen_pkg: shared end-screen palette, widths and encoder state type
package endscreen_pkg;
    localparam int IDX_W   = 3;
    localparam int DIST_W  = 10;
    localparam int NUM_PAL = 8;
    localparam logic [11:0] PALETTE [NUM_PAL] = '{
        12'h000, 12'hE79, 12'h169, 12'h931,
        12'h8CD, 12'hEB8, 12'h510, 12'hB75
    };
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
endpackage

// File: rtl/color_sq_dist.sv
// color_sq_dist: squared euclidean distance between two 4:4:4 RGB colours
module color_sq_dist
    import endscreen_pkg::*;
(
    input  logic [11:0]       i_a,
    input  logic [11:0]       i_b,
    output logic [DIST_W-1:0] o_dist
);
    logic [7:0] w_sq [3];

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [3:0] w_x, w_y, w_d;
        assign w_x     = i_a[4*c +: 4];
        assign w_y     = i_b[4*c +: 4];
        assign w_d     = w_x > w_y ? w_x - w_y : w_y - w_x;
        assign w_sq[c] = {4'b0, w_d} * {4'b0, w_d};
    end

    assign o_dist = {2'b0, w_sq[0]} + {2'b0, w_sq[1]} + {2'b0, w_sq[2]};
endmodule

// File: rtl/endscreen_palette_encoder.sv
// endscreen_palette_encoder: maps an RGB pixel to the nearest end-screen palette
// index, searching one entry per cycle behind valid/ready handshakes.
module endscreen_palette_encoder
    import endscreen_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter bit EARLY_EXIT  = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        red,
    input  logic [3:0]        green,
    input  logic [3:0]        blue,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  index,
    output logic [DIST_W-1:0] distance
);
    state_t              r_state, w_next;
    logic [11:0]         r_px;
    logic [IDX_W-1:0]    r_k, r_best_i, r_index, w_new_i;
    logic [DIST_W-1:0]   r_best_d, r_dist, w_d, w_new_d;
    logic                w_better, w_last;

    color_sq_dist u_dist (
        .i_a    (r_px),
        .i_b    (PALETTE[r_k]),
        .o_dist (w_d)
    );

    // strict compare keeps the lower index on ties
    assign w_better = w_d < r_best_d;
    assign w_new_i  = w_better ? r_k : r_best_i;
    assign w_new_d  = w_better ? w_d : r_best_d;
    assign w_last   = r_k == IDX_W'(NUM_ENTRIES - 1) || (EARLY_EXIT && w_d == '0);

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign index     = r_index;
    assign distance  = r_dist;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_valid)   w_next = SEARCH;
        if (r_state == SEARCH && w_last)   w_next = DONE;
        if (r_state == DONE && out_ready)  w_next = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_px     <= '0;
            r_k      <= '0;
            r_best_i <= '0;
            r_best_d <= '1;
            r_index  <= '0;
            r_dist   <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_px     <= {red, green, blue};
                r_k      <= '0;
                r_best_i <= '0;
                r_best_d <= '1;
            end
            if (r_state == SEARCH) begin
                r_k      <= r_k + 1'b1;
                r_best_i <= w_new_i;
                r_best_d <= w_new_d;
                if (w_last) begin
                    r_index <= w_new_i;
                    r_dist  <= w_new_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_endscreen_palette_encoder.sv
// tb_endscreen_palette_encoder: directed and streaming checks of the palette
// encoder against an independent nearest-colour model.
module tb_endscreen_palette_encoder;
    logic        Clk = 0, Reset_n = 0, in_valid = 0, out_ready = 0;
    logic [3:0]  red = 0, green = 0, blue = 0;
    logic        in_ready, out_valid;
    logic [2:0]  index;
    logic [9:0]  distance;

    int          n_cmp = 0, n_err = 0;
    logic [12:0] q [$];
    logic [11:0] pal [8] = '{12'h000, 12'hE79, 12'h169, 12'h931,
                             12'h8CD, 12'hEB8, 12'h510, 12'hB75};

    endscreen_palette_encoder dut (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .red(red), .green(green), .blue(blue), .out_valid(out_valid),
        .out_ready(out_ready), .index(index), .distance(distance)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [11:0] px);
        int best = 1023, bi = 0;
        for (int k = 0; k < 8; k++) begin
            logic [11:0] p;
            int dr, dg, db, d;
            p  = pal[k];
            dr = int'(px[11:8]) - int'(p[11:8]);
            dg = int'(px[7:4])  - int'(p[7:4]);
            db = int'(px[3:0])  - int'(p[3:0]);
            d  = dr*dr + dg*dg + db*db;
            if (d < best) begin best = d; bi = k; end
        end
        return {3'(bi), 10'(best)};
    endfunction

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic send(input logic [11:0] px);
        int n = 0;
        {red, green, blue} = px;
        in_valid = 1;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 0;
        q.push_back(model(px));
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [2:0] ei, input logic [9:0] ed);
        logic [12:0] e;
        e = q.size() > 0 ? q.pop_front() : 13'bx;
        chk({tag, "_index_model"}, index, e[12:10]);
        chk({tag, "_dist_model"}, distance, e[9:0]);
        chk({tag, "_index"}, index, ei);
        chk({tag, "_dist"}, distance, ed);
    endtask

    task automatic take(input string tag);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic run_px(input string tag, input logic [11:0] px, input int lat,
                          input logic [2:0] ei, input logic [9:0] ed);
        send(px);
        wait_out(tag, lat);
        check_result(tag, ei, ed);
    endtask

    initial begin
        int got = 0, cyc = 0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_index", index, 0);
        chk("rst_distance", distance, 0);
        @(negedge Clk) Reset_n = 1;
        tick();

        run_px("black", 12'h000, 1, 3'd0, 10'd0);
        take("black");
        run_px("white", 12'hFFF, 8, 3'd4, 10'd62);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_index", index, 4);
            chk("bp_dist", distance, 62);
            chk("bp_in_ready", in_ready, 0);
        end
        take("white");
        run_px("tie", 12'hC97, 8, 3'd5, 10'd9);
        take("tie");
        run_px("last", 12'hB75, 8, 3'd7, 10'd0);
        take("last");

        // latched pixel must survive input changes during the search
        send(12'h931);
        {red, green, blue} = 12'h000;
        wait_out("latched", 4);
        check_result("latched", 3'd3, 10'd0);
        take("latched");

        send(12'hFFF);
        tick(); tick(); tick();
        #2 Reset_n = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_distance", distance, 0);
        q.delete();
        @(negedge Clk) Reset_n = 1;
        tick();
        run_px("post_rst", 12'hE79, 2, 3'd1, 10'd0);
        take("post_rst");

        out_ready = 1;
        fork
            for (int p = 0; p < 4096; p++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(12'(p));
            end
            while (got < 4096 && cyc < 80000) begin
                tick();
                cyc++;
                if (out_valid) begin
                    logic [12:0] e;
                    e = q.size() > 0 ? q.pop_front() : 13'bx;
                    chk("stream_index", index, e[12:10]);
                    chk("stream_dist", distance, e[9:0]);
                    got++;
                end
            end
        join
        repeat (12) begin
            tick();
            chk("stream_no_extra", out_valid, 0);
        end
        chk("stream_count", got, 4096);
        chk("stream_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
